// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction prefetch: sequential word fetches over a valid/ready channel,
// in-order responses buffered in a small queue and handed to the core as {inst, pc}.
module riscv_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q,  head_pc_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] live_q,     live_d;
    logic [CW-1:0] drop_q,     drop_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [31:0]   mem_q [DEPTH];

    logic [SW-1:0] pending_sum;
    logic          credit_ok;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_keep;
    logic          resp_consumed;
    logic          wr_en;
    logic          pop;
    logic [31:0]   redirect_aligned;

    // Credit counts every slot that is occupied or may still be filled by a response.
    assign pending_sum = SW'(live_q) + SW'(drop_q) + SW'(count_q);
    assign credit_ok   = (pending_sum < DEPTH_S);

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop     = imem_resp_valid && (drop_q != '0);
    assign resp_keep     = imem_resp_valid && (drop_q == '0) && (live_q != '0);
    assign resp_consumed = resp_drop || resp_keep;
    assign wr_en         = resp_keep && !redirect_valid && !rst;

    assign inst_valid = !rst && (count_q != '0);
    assign inst_data  = mem_q[rd_ptr_q];
    assign inst_pc    = head_pc_q;
    assign pop        = inst_valid && inst_ready && !redirect_valid;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        count_d    = count_q;
        live_d     = live_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response landing now is already gone.
            fetch_pc_d = redirect_aligned;
            head_pc_d  = redirect_aligned;
            count_d    = '0;
            live_d     = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = drop_q + live_q - CW'(resp_consumed);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (pop) begin
                head_pc_d = head_pc_q + 32'd4;
                rd_ptr_d  = rd_ptr_q + AW'(1);
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            live_d  = live_q + CW'(req_fire) - CW'(wr_en);
            count_d = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            count_q    <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            count_q    <= count_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

`ifndef SYNTHESIS
    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        pending_sum <= DEPTH_S);
    a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (live_q != '0 || drop_q != '0));
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed scenarios plus a long random run, all checked
// against a queue-level model of the fetch stream and a variable-latency memory.
module tb_riscv_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    riscv_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [31:0] instq[$];
    logic [31:0] exp_fetch = RESET_PC;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_checks = 0;
    int          n_errors = 0;

    bit          s_inst_valid;
    bit          s_fire;
    bit          s_pop;
    logic [31:0] s_pop_pc;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare just after, advance the model at posedge.
    task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc,
                         input bit ir, input bit qr, input bit allow_resp);
        bit   resp, exp_iv, exp_rv, m_fire, m_pop;
        req_t e;
        @(negedge clk);
        rst            = r;
        redirect_valid = rd && !r;
        redirect_pc    = rpc;
        inst_ready     = ir;
        imem_req_ready = qr;
        resp = !r && allow_resp && (pend.size() > 0) && (pend[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(pend[0].addr) : $urandom;
        #1;
        exp_iv = !r && (instq.size() != 0);
        exp_rv = !r && !redirect_valid && ((pend.size() + instq.size()) < DEPTH);
        check_val("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv && inst_valid) begin
            check_val("inst_pc", inst_pc, instq[0]);
            check_val("inst_data", inst_data, mem_word(instq[0]));
        end
        check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv && imem_req_valid) begin
            check_val("req_addr", imem_req_addr, exp_fetch);
        end
        s_inst_valid = inst_valid;
        s_fire       = imem_req_valid && qr;
        s_pop        = inst_valid && ir && !redirect_valid;
        s_pop_pc     = inst_pc;
        s_req_addr   = imem_req_addr;
        m_fire = exp_rv && qr;
        m_pop  = exp_iv && ir && !redirect_valid;
        @(posedge clk);
        if (r) begin
            pend.delete();
            instq.delete();
            exp_fetch = RESET_PC;
        end else if (redirect_valid) begin
            if (resp) e = pend.pop_front();
            foreach (pend[i]) pend[i].stale = 1'b1;
            instq.delete();
            exp_fetch = rpc & 32'hFFFF_FFFC;
        end else begin
            if (resp) begin
                e = pend.pop_front();
                if (!e.stale) instq.push_back(e.addr);
            end
            if (m_pop) void'(instq.pop_front());
            if (m_fire) begin
                e.addr  = exp_fetch;
                e.due   = cyc + $urandom_range(lat_max, lat_min);
                e.stale = 1'b0;
                pend.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_valid, nf, first_pop, first_fire, np;
        logic [31:0] pcs[8];

        // Zero-wait memory: first instruction two cycles after reset release.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        first_valid = -1; np = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_inst_valid && first_valid < 0) first_valid = k;
            if (s_pop && np < 8) begin pcs[np] = s_pop_pc; np++; end
        end
        check_val("first_valid_cycle", first_valid, 2);
        for (int i = 0; i < 4; i++) check_val("stream_pc", pcs[i], 32'(i * 4));

        // Backpressure fills the queue; draining frees credit one cycle after the pop.
        do_reset(1);
        nf = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            if (s_fire) nf++;
        end
        check_val("fill_fires", nf, DEPTH);
        first_pop = -1; first_fire = -1; np = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_pop && first_pop < 0) first_pop = k;
            if (s_fire && first_fire < 0) begin
                first_fire = k;
                check_val("refill_addr", s_req_addr, 32'h10);
            end
            if (s_pop && np < 8) begin pcs[np] = s_pop_pc; np++; end
        end
        check_val("refill_after_pop", first_fire, first_pop + 1);
        for (int i = 0; i < 4; i++) check_val("drain_pc", pcs[i], 32'(i * 4));

        // Three requests in flight at latency 3, then redirect discards them.
        do_reset(1);
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        lat_min = 1; lat_max = 1;
        np = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_pop && np < 8) begin pcs[np] = s_pop_pc; np++; end
        end
        check_val("post_redirect_pc", pcs[0], 32'h100);

        // Unaligned redirect colliding with a pop request and a response.
        do_reset(1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h203, 1'b1, 1'b1, 1'b1);
        check_val("redirect_no_pop", 32'(s_pop), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_val("redirect_addr", s_req_addr, 32'h200);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Memory stalls acceptance; address must hold.
        do_reset(1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_val("stall_addr", s_req_addr, RESET_PC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_val("stall_accept", 32'(s_fire), 32'h1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // PC wrap across 2^32, then reset mid-stream.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        np = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_pop && np < 8) begin pcs[np] = s_pop_pc; np++; end
        end
        check_val("wrap_pc0", pcs[0], 32'hFFFF_FFF8);
        check_val("wrap_pc1", pcs[1], 32'hFFFF_FFFC);
        check_val("wrap_pc2", pcs[2], 32'h0000_0000);
        do_reset(1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check_val("rst_inst_valid", 32'(s_inst_valid), 32'h0);
        check_val("rst_fetch_addr", s_req_addr, RESET_PC);

        // Random traffic: variable latency, backpressure on both sides, redirects and resets.
        lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            bit r, rd, ir, qr, ar;
            r  = ($urandom_range(0, 999) < 5);
            rd = ($urandom_range(0, 99) < 3);
            ir = ($urandom_range(0, 99) < 70);
            qr = ($urandom_range(0, 99) < 75);
            ar = ($urandom_range(0, 99) < 80);
            cycle(r, rd, $urandom, ir, qr, ar);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
